// File: rtl/calc_pkg.sv
// Purpose: shared token encoding, ALU opcodes, parser states and token decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

  localparam int TOK_W      = 5;
  localparam int TOK_OP_BIT = 4;   // 1 = operator token, 0 = key token

  // Operator codes carried in tok[2:0] when tok[4:3] == 2'b10
  localparam logic [2:0] OP_AC  = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    A_ENTRY,
    OP_SEL,
    B_ENTRY,
    ISSUE,
    WAIT_RES,
    RESULT,
    ERROR
  } parser_state_e;

  // Decimal key 0..9; keys 10..15 are legal tokens but carry no meaning
  function automatic logic is_digit(input logic [TOK_W-1:0] tok);
    return !tok[TOK_OP_BIT] && (tok[3:0] <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [TOK_W-1:0] tok, input logic [2:0] op);
    return tok[TOK_OP_BIT] && !tok[3] && (tok[2:0] == op);
  endfunction

  // One of + - * /
  function automatic logic is_arith(input logic [TOK_W-1:0] tok);
    return tok[TOK_OP_BIT] && !tok[3] && (tok[2:0] >= OP_ADD) && (tok[2:0] <= OP_DIV);
  endfunction

  function automatic opcode_e to_opcode(input logic [2:0] op);
    opcode_e r;
    case (op)
      OP_SUB:  r = SUB;
      OP_MUL:  r = MUL;
      OP_DIV:  r = DIV;
      default: r = ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_token_parser_digit_accumulator.sv
// Purpose: decimal operand register; clear, parallel load, or append one digit (v*10+d).
// Latency: new value visible the cycle after the control strobe; o_value_next is the combinational preview.
// Backpressure: none; appends beyond MAX_DIGITS are silently dropped.
// Ports: i_clear/i_load/i_append (priority in that order), i_load_val/i_load_cnt, i_digit,
//        o_value (registered), o_value_next (value after this cycle's update).
module digit_accumulator #(
  parameter int  WIDTH      = 16,
  parameter int  MAX_DIGITS = 4,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_load_cnt,
  input  logic             i_append,
  input  logic [3:0]       i_digit,
  output logic [WIDTH-1:0] o_value,
  output logic [WIDTH-1:0] o_value_next
);

  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] times_ten;

  always_comb begin
    value_d   = value_q;
    count_d   = count_q;
    // x10 built from shifts so no multiplier is inferred
    times_ten = (value_q << 3) + (value_q << 1);
    if (i_clear) begin
      value_d = '0;
      count_d = '0;
    end else if (i_load) begin
      value_d = i_load_val;
      count_d = i_load_cnt;
    end else if (i_append && (count_q < CNT_W'(MAX_DIGITS))) begin
      value_d = times_ten + {{(WIDTH-4){1'b0}}, i_digit};
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign o_value      = value_q;
  assign o_value_next = value_d;

endmodule

// File: rtl/key_token_parser.sv
// Purpose: turns keypad tokens into {A, B, opcode} ALU commands, chains ops on the result, drives the display.
// Latency: each accepted token takes effect next cycle; a command is offered the cycle after '=' or a chaining op.
// Backpressure: o_ready drops while a command is outstanding (ISSUE/WAIT_RES); o_valid holds until i_ready.
// Ports: token in (i_data/i_valid/o_ready), ALU command out (o_op_a/o_op_b/o_opcode/o_valid/i_ready),
//        ALU result in (i_result/i_result_valid/i_result_err), status out (o_display/o_error/o_clear).
module key_token_parser
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic [1:0]       o_opcode,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_result_valid,
  input  logic             i_result_err,
  output logic [WIDTH-1:0] o_display,
  output logic             o_error,
  output logic             o_clear
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  parser_state_e    state_q, state_d;
  opcode_e          op_q, op_d;
  opcode_e          pend_q, pend_d;
  logic             chain_q, chain_d;
  logic             error_q, error_d;
  logic             clear_q, clear_d;
  logic [WIDTH-1:0] display_q, display_d;

  logic             a_clear, a_load, a_append;
  logic [WIDTH-1:0] a_load_val, a_val, a_next;
  logic [CNT_W-1:0] a_load_cnt;
  logic             b_clear, b_load, b_append;
  logic [WIDTH-1:0] b_val, b_next;

  logic             accept;
  logic [WIDTH-1:0] digit_val;

  assign o_ready   = (state_q != ISSUE) && (state_q != WAIT_RES);
  assign accept    = i_valid && o_ready;
  assign digit_val = {{(WIDTH-4){1'b0}}, i_data[3:0]};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pend_d     = pend_q;
    chain_d    = chain_q;
    error_d    = error_q;
    clear_d    = 1'b0;
    a_clear    = 1'b0;
    a_load     = 1'b0;
    a_append   = 1'b0;
    a_load_val = digit_val;
    a_load_cnt = CNT_W'(1);
    b_clear    = 1'b0;
    b_load     = 1'b0;
    b_append   = 1'b0;

    if (accept && is_op(i_data, OP_AC)) begin
      // AC wins in every state that can accept a token, including ERROR
      a_clear = 1'b1;
      b_clear = 1'b1;
      error_d = 1'b0;
      clear_d = 1'b1;
      op_d    = ADD;
      chain_d = 1'b0;
      state_d = A_ENTRY;
    end else begin
      case (state_q)
        A_ENTRY: if (accept) begin
          if (is_digit(i_data)) begin
            a_append = 1'b1;
          end else if (is_arith(i_data)) begin
            op_d    = to_opcode(i_data[2:0]);
            state_d = OP_SEL;
          end
        end
        OP_SEL: if (accept) begin
          if (is_digit(i_data)) begin
            b_load  = 1'b1;
            state_d = B_ENTRY;
          end else if (is_arith(i_data)) begin
            op_d = to_opcode(i_data[2:0]);
          end
        end
        B_ENTRY: if (accept) begin
          if (is_digit(i_data)) begin
            b_append = 1'b1;
          end else if (is_arith(i_data)) begin
            // The new op applies to the result of this command
            pend_d  = to_opcode(i_data[2:0]);
            chain_d = 1'b1;
            state_d = ISSUE;
          end else if (is_op(i_data, OP_EQ)) begin
            chain_d = 1'b0;
            state_d = ISSUE;
          end
        end
        RESULT: if (accept) begin
          if (is_digit(i_data)) begin
            // A fresh digit abandons the result and starts a new A
            a_load  = 1'b1;
            state_d = A_ENTRY;
          end else if (is_arith(i_data)) begin
            op_d    = to_opcode(i_data[2:0]);
            state_d = OP_SEL;
          end
        end
        ISSUE: if (i_ready) begin
          state_d = WAIT_RES;
        end
        WAIT_RES: if (i_result_valid) begin
          if (i_result_err) begin
            error_d = 1'b1;
            state_d = ERROR;
          end else begin
            // Full count stops digits from being appended to a result
            a_load     = 1'b1;
            a_load_val = i_result;
            a_load_cnt = CNT_W'(MAX_DIGITS);
            b_clear    = 1'b1;
            if (chain_q) begin
              op_d    = pend_q;
              state_d = OP_SEL;
            end else begin
              state_d = RESULT;
            end
          end
        end
        ERROR:   ;
        default: state_d = A_ENTRY;
      endcase
    end

    // Display follows the next-cycle state so it lines up with state_q
    case (state_d)
      B_ENTRY: display_d = b_next;
      ERROR:   display_d = '0;
      default: display_d = a_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= A_ENTRY;
      op_q      <= ADD;
      pend_q    <= ADD;
      chain_q   <= 1'b0;
      error_q   <= 1'b0;
      clear_q   <= 1'b0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pend_q    <= pend_d;
      chain_q   <= chain_d;
      error_q   <= error_d;
      clear_q   <= clear_d;
      display_q <= display_d;
    end
  end

  digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (a_clear),
    .i_load       (a_load),
    .i_load_val   (a_load_val),
    .i_load_cnt   (a_load_cnt),
    .i_append     (a_append),
    .i_digit      (i_data[3:0]),
    .o_value      (a_val),
    .o_value_next (a_next)
  );

  digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (b_clear),
    .i_load       (b_load),
    .i_load_val   (digit_val),
    .i_load_cnt   (CNT_W'(1)),
    .i_append     (b_append),
    .i_digit      (i_data[3:0]),
    .o_value      (b_val),
    .o_value_next (b_next)
  );

  assign o_valid   = (state_q == ISSUE);
  assign o_op_a    = a_val;
  assign o_op_b    = b_val;
  assign o_opcode  = op_q;
  assign o_display = display_q;
  assign o_error   = error_q;
  assign o_clear   = clear_q;

endmodule

// File: tb/tb_key_token_parser.sv
// Purpose: self-checking bench for key_token_parser: directed scenarios plus randomized token streams.
// Latency: checks sampled 1ns after the rising edge that commits each action.
// Backpressure: tokens wait on o_ready (bounded); the bench acts as the ALU with random ready/result delays.
module tb_key_token_parser;

  localparam int MAXD = 4;
  localparam logic [4:0] T_AC  = 5'h10;
  localparam logic [4:0] T_ADD = 5'h11;
  localparam logic [4:0] T_SUB = 5'h12;
  localparam logic [4:0] T_MUL = 5'h13;
  localparam logic [4:0] T_DIV = 5'h14;
  localparam logic [4:0] T_EQ  = 5'h15;

  // Behavioural calculator view
  localparam int M_A = 0, M_OPS = 1, M_B = 2, M_BUSY = 3, M_RES = 4, M_ERR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] o_op_a, o_op_b;
  logic [1:0]  o_opcode;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] i_result = '0;
  logic        i_result_valid = 1'b0;
  logic        i_result_err = 1'b0;
  logic [15:0] o_display;
  logic        o_error;
  logic        o_clear;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_mode;
  int unsigned m_a, m_b;
  int          m_acnt, m_bcnt, m_op, m_pend;
  bit          m_chain, m_err;

  always #5 clk = ~clk;

  key_token_parser #(.WIDTH(16), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_opcode(o_opcode), .o_valid(o_valid), .i_ready(i_ready),
    .i_result(i_result), .i_result_valid(i_result_valid), .i_result_err(i_result_err),
    .o_display(o_display), .o_error(o_error), .o_clear(o_clear)
  );

  function automatic void model_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
    m_op = 0; m_pend = 0; m_chain = 0; m_err = 0;
  endfunction

  function automatic void model_token(input logic [4:0] t);
    int d;
    int o;
    d = int'(t[3:0]);
    o = int'(t[2:0]);
    if (t == T_AC) begin
      model_reset();
      return;
    end
    if (m_mode == M_ERR) return;
    if (!t[4]) begin
      if (d > 9) return;
      if (m_mode == M_A) begin
        if (m_acnt < MAXD) begin m_a = (m_a * 10 + d) & 32'hFFFF; m_acnt++; end
      end else if (m_mode == M_B) begin
        if (m_bcnt < MAXD) begin m_b = (m_b * 10 + d) & 32'hFFFF; m_bcnt++; end
      end else if (m_mode == M_OPS) begin
        m_b = d; m_bcnt = 1; m_mode = M_B;
      end else if (m_mode == M_RES) begin
        m_a = d; m_acnt = 1; m_mode = M_A;
      end
    end else if (!t[3]) begin
      if (o >= 1 && o <= 4) begin
        if (m_mode == M_B) begin m_pend = o - 1; m_chain = 1; m_mode = M_BUSY; end
        else if (m_mode != M_BUSY) begin m_op = o - 1; m_mode = M_OPS; end
      end else if (o == 5 && m_mode == M_B) begin
        m_chain = 0; m_mode = M_BUSY;
      end
    end
  endfunction

  function automatic void model_result(input int unsigned r, input bit err);
    if (err) begin m_err = 1; m_mode = M_ERR; return; end
    m_a = r & 32'hFFFF; m_acnt = MAXD; m_b = 0; m_bcnt = 0;
    if (m_chain) begin m_op = m_pend; m_mode = M_OPS; end
    else m_mode = M_RES;
  endfunction

  function automatic logic [15:0] model_display();
    int unsigned v;
    if (m_mode == M_B) v = m_b;
    else if (m_mode == M_ERR) v = 0;
    else v = m_a;
    return v[15:0];
  endfunction

  function automatic int unsigned alu_ref(input int op, input int unsigned a, input int unsigned b);
    case (op)
      0:       return (a + b) & 32'hFFFF;
      1:       return (a - b) & 32'hFFFF;
      2:       return (a * b) & 32'hFFFF;
      default: return (b == 0) ? 0 : (a / b);
    endcase
  endfunction

  task automatic send_tok(input logic [4:0] t);
    int n;
    n = 0;
    @(negedge clk);
    i_data = t; i_valid = 1'b1;
    while (!o_ready && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (!o_ready) begin
      $display("FAIL tok_timeout token=%0h o_ready=%0b want 1", t, o_ready);
      i_valid = 1'b0;
    end else begin
      n_pass++;
      @(posedge clk); #1;
      i_valid = 1'b0;
      model_token(t);
    end
  endtask

  task automatic alu_accept(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1; i_ready = 1'b0;
  endtask

  task automatic alu_respond(input int delay, input logic [15:0] r, input bit err);
    repeat (delay) @(posedge clk);
    @(negedge clk); i_result = r; i_result_err = err; i_result_valid = 1'b1;
    @(posedge clk); #1; i_result_valid = 1'b0; i_result_err = 1'b0;
    model_result(int'(r), err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({o_valid, o_error, o_clear} !== 3'b000) $display("FAIL rst_flags got %b want 000", {o_valid, o_error, o_clear}); else n_pass++;
    n_checks++; if (o_display !== 16'd0) $display("FAIL rst_display got %0d want 0", o_display); else n_pass++;
    n_checks++; if ({o_op_a, o_op_b, o_opcode} !== 34'd0) $display("FAIL rst_cmd got a=%0d b=%0d opc=%0d want 0", o_op_a, o_op_b, o_opcode); else n_pass++;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    send_tok(5'd1); send_tok(5'd2); send_tok(5'd3);
    n_checks++; if (o_display !== 16'd123) $display("FAIL basic_a got %0d want 123", o_display); else n_pass++;
    send_tok(T_ADD);
    n_checks++; if (o_display !== 16'd123) $display("FAIL basic_opsel_disp got %0d want 123", o_display); else n_pass++;
    send_tok(5'd4);
    n_checks++; if (o_display !== 16'd4) $display("FAIL basic_b got %0d want 4", o_display); else n_pass++;
    send_tok(T_EQ);
    n_checks++; if ({o_valid, o_ready} !== 2'b10) $display("FAIL basic_issue got v/r=%b want 10", {o_valid, o_ready}); else n_pass++;
    n_checks++; if ({o_op_a, o_op_b, o_opcode} !== {16'd123, 16'd4, 2'b00}) $display("FAIL basic_cmd got a=%0d b=%0d opc=%0d want 123 4 0", o_op_a, o_op_b, o_opcode); else n_pass++;
    alu_accept(0);
    n_checks++; if ({o_valid, o_ready} !== 2'b00) $display("FAIL basic_wait got v/r=%b want 00", {o_valid, o_ready}); else n_pass++;
    alu_respond(2, 16'd127, 1'b0);
    n_checks++; if ({o_display, o_ready} !== {16'd127, 1'b1}) $display("FAIL basic_result got %0d rdy=%b want 127 1", o_display, o_ready); else n_pass++;
    send_tok(5'd5);
    n_checks++; if (o_display !== 16'd5) $display("FAIL basic_result_digit got %0d want 5", o_display); else n_pass++;
  endtask

  task automatic test_digit_limit();
    send_tok(T_AC);
    n_checks++; if ({o_clear, o_display} !== {1'b1, 16'd0}) $display("FAIL lim_ac got clr=%b disp=%0d want 1 0", o_clear, o_display); else n_pass++;
    repeat (4) send_tok(5'd9);
    n_checks++; if (o_display !== 16'd9999) $display("FAIL lim_4dig got %0d want 9999", o_display); else n_pass++;
    send_tok(5'd9);
    n_checks++; if (o_display !== 16'd9999) $display("FAIL lim_5th_dropped got %0d want 9999", o_display); else n_pass++;
    send_tok(5'd12);
    n_checks++; if ({o_display, o_ready} !== {16'd9999, 1'b1}) $display("FAIL lim_key12 got %0d rdy=%b want 9999 1", o_display, o_ready); else n_pass++;
    @(negedge clk); i_result = 16'd555; i_result_valid = 1'b1;
    @(posedge clk); #1; i_result_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_display !== 16'd9999) $display("FAIL lim_stray_result got %0d want 9999", o_display); else n_pass++;
  endtask

  task automatic test_op_replace();
    send_tok(T_AC); send_tok(5'd8); send_tok(T_SUB); send_tok(T_ADD); send_tok(5'd2); send_tok(T_EQ);
    n_checks++; if ({o_valid, o_op_a, o_op_b, o_opcode} !== {1'b1, 16'd8, 16'd2, 2'b00}) $display("FAIL rep_cmd got v=%b a=%0d b=%0d opc=%0d want 1 8 2 0", o_valid, o_op_a, o_op_b, o_opcode); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if ({o_valid, o_ready, o_op_a, o_op_b, o_opcode} !== {2'b10, 16'd8, 16'd2, 2'b00}) $display("FAIL rep_hold%0d got v=%b r=%b a=%0d b=%0d opc=%0d", c, o_valid, o_ready, o_op_a, o_op_b, o_opcode); else n_pass++;
    end
    alu_accept(0);
    alu_respond(0, 16'd10, 1'b0);
    n_checks++; if (o_display !== 16'd10) $display("FAIL rep_result got %0d want 10", o_display); else n_pass++;
  endtask

  task automatic test_chain();
    send_tok(T_AC); send_tok(5'd6); send_tok(T_MUL); send_tok(5'd7); send_tok(T_ADD);
    n_checks++; if ({o_valid, o_op_a, o_op_b, o_opcode} !== {1'b1, 16'd6, 16'd7, 2'b10}) $display("FAIL chain_mul got v=%b a=%0d b=%0d opc=%0d want 1 6 7 2", o_valid, o_op_a, o_op_b, o_opcode); else n_pass++;
    alu_accept(1);
    alu_respond(1, 16'd42, 1'b0);
    n_checks++; if ({o_display, o_ready, o_valid} !== {16'd42, 2'b10}) $display("FAIL chain_res got %0d r=%b v=%b want 42 1 0", o_display, o_ready, o_valid); else n_pass++;
    send_tok(5'd1);
    n_checks++; if (o_display !== 16'd1) $display("FAIL chain_b got %0d want 1", o_display); else n_pass++;
    send_tok(T_EQ);
    n_checks++; if ({o_valid, o_op_a, o_op_b, o_opcode} !== {1'b1, 16'd42, 16'd1, 2'b00}) $display("FAIL chain_add got v=%b a=%0d b=%0d opc=%0d want 1 42 1 0", o_valid, o_op_a, o_op_b, o_opcode); else n_pass++;
    alu_accept(0);
    alu_respond(0, 16'd43, 1'b0);
    n_checks++; if (o_display !== 16'd43) $display("FAIL chain_final got %0d want 43", o_display); else n_pass++;
  endtask

  task automatic test_div_zero();
    send_tok(T_AC); send_tok(5'd5); send_tok(T_DIV); send_tok(5'd0); send_tok(T_EQ);
    n_checks++; if ({o_valid, o_op_a, o_op_b, o_opcode} !== {1'b1, 16'd5, 16'd0, 2'b11}) $display("FAIL dz_cmd got v=%b a=%0d b=%0d opc=%0d want 1 5 0 3", o_valid, o_op_a, o_op_b, o_opcode); else n_pass++;
    alu_accept(0);
    alu_respond(1, 16'd0, 1'b1);
    n_checks++; if ({o_error, o_display, o_ready} !== {1'b1, 16'd0, 1'b1}) $display("FAIL dz_err got e=%b d=%0d r=%b want 1 0 1", o_error, o_display, o_ready); else n_pass++;
    send_tok(5'd3);
    n_checks++; if ({o_error, o_display} !== {1'b1, 16'd0}) $display("FAIL dz_ignore got e=%b d=%0d want 1 0", o_error, o_display); else n_pass++;
    send_tok(T_AC);
    n_checks++; if ({o_clear, o_error, o_display} !== {2'b10, 16'd0}) $display("FAIL dz_ac got c=%b e=%b d=%0d want 1 0 0", o_clear, o_error, o_display); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_clear !== 1'b0) $display("FAIL dz_clear_pulse got %b want 0", o_clear); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_tok(T_AC); send_tok(5'd1); send_tok(T_ADD); send_tok(5'd2);
    n_checks++; if (o_display !== 16'd2) $display("FAIL mid_b got %0d want 2", o_display); else n_pass++;
    send_tok(T_EQ);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL mid_issue got %b want 1", o_valid); else n_pass++;
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++; if ({o_valid, o_display, o_ready, o_op_a} !== {1'b0, 16'd0, 1'b1, 16'd0}) $display("FAIL mid_rst got v=%b d=%0d r=%b a=%0d want 0 0 1 0", o_valid, o_display, o_ready, o_op_a); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    send_tok(5'd7);
    n_checks++; if (o_display !== 16'd7) $display("FAIL mid_after got %0d want 7", o_display); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0]  t;
    int          r;
    int unsigned res;
    bit          err;
    send_tok(T_AC);
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      t = 5'($urandom_range(0, 9));
      else if (r < 60) t = 5'($urandom_range(10, 15));
      else if (r < 85) t = {2'b10, 3'($urandom_range(1, 4))};
      else if (r < 96) t = T_EQ;
      else             t = T_AC;
      send_tok(t);
      n_checks++; if ({o_display, o_error} !== {model_display(), m_err}) $display("FAIL rnd_tok%0d tok=%0h got d=%0d e=%b want d=%0d e=%b", i, t, o_display, o_error, model_display(), m_err); else n_pass++;
      if (m_mode == M_BUSY) begin
        n_checks++; if ({o_valid, o_ready, o_op_a, o_op_b, o_opcode} !== {2'b10, m_a[15:0], m_b[15:0], m_op[1:0]}) $display("FAIL rnd_cmd%0d got v=%b a=%0d b=%0d opc=%0d want 1 %0d %0d %0d", i, o_valid, o_op_a, o_op_b, o_opcode, m_a, m_b, m_op); else n_pass++;
        err = (m_op == 3) && (m_b == 0);
        res = alu_ref(m_op, m_a, m_b);
        alu_accept(int'($urandom_range(0, 2)));
        alu_respond(int'($urandom_range(0, 3)), res[15:0], err);
        n_checks++; if ({o_display, o_error, o_ready} !== {model_display(), m_err, 1'b1}) $display("FAIL rnd_res%0d got d=%0d e=%b r=%b want d=%0d e=%b r=1", i, o_display, o_error, o_ready, model_display(), m_err); else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_digit_limit();
    test_op_replace();
    test_chain();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
